// File: rtl/l2_arbiter.sv
// Round-robin arbiter between I-cache and D-cache miss ports onto one L2 port.
// The granted request is registered so L2 sees a stable address/line/op.
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic d_req;
    logic grant_i;
    logic grant_d;

    // On contention the client that was not served last wins.
    assign d_req   = d_read | d_write;
    assign grant_d = d_req & (~i_read | ~last_d_q);
    assign grant_i = i_read & (~d_req | last_d_q);

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d  = SERVE_D;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    wr_d     = d_write;
                    last_d_d = 1'b1;
                end else if (grant_i) begin
                    state_d  = SERVE_I;
                    addr_d   = i_addr;
                    wr_d     = 1'b0;
                    last_d_d = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign l2_read  = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~wr_q);
    assign l2_write = (state_q == SERVE_D) & wr_q;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;

    assign i_resp  = (state_q == SERVE_I) & l2_resp;
    assign d_resp  = (state_q == SERVE_D) & l2_resp;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // Simultaneous read and write from the D-cache is a client bug.
    a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: vector table plus hand-written contention/reset
// sequences, with a scoreboard queue popped on every client response.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [15:0]  i_addr;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_addr;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;

    l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_resp   (i_resp),
        .i_rdata  (i_rdata),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_resp   (d_resp),
        .d_rdata  (d_rdata),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_resp  (l2_resp),
        .l2_rdata (l2_rdata)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] PAT = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    typedef struct {
        bit           cli;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           lat;
    } vec_t;

    typedef struct {
        bit           cli;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   l2_lat = 1;
    bit   l2_auto = 1'b1;

    function automatic logic [127:0] line_of(logic [15:0] a);
        return {8{a ^ 16'hA5C3}};
    endfunction

    function automatic exp_t mk(bit cli, bit wr, logic [15:0] a, logic [127:0] w);
        exp_t e;
        e.cli = cli;
        e.wr = wr;
        e.addr = a;
        e.wdata = w;
        return e;
    endfunction

    task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // L2 memory model: answers after l2_lat cycles of an active request.
    initial begin
        int cnt = 0;
        l2_resp = 1'b0;
        l2_rdata = '0;
        forever begin
            @(negedge clk);
            if (!l2_auto) begin
                cnt = 0;
            end else if (l2_resp) begin
                l2_resp = 1'b0;
                cnt = 0;
            end else if (l2_read || l2_write) begin
                cnt++;
                if (cnt >= l2_lat) begin
                    l2_resp = 1'b1;
                    l2_rdata = line_of(l2_addr);
                end
            end
        end
    end

    // Scoreboard: every client response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (i_resp || d_resp) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_resp i=%b d=%b exp=none", i_resp, d_resp);
                end else begin
                    e = q.pop_front();
                    chk("resp_client", {126'd0, i_resp, d_resp}, e.cli ? 128'd1 : 128'd2);
                    chk("rdata", e.cli ? d_rdata : i_rdata, line_of(e.addr));
                    chk("l2_addr", {112'd0, l2_addr}, {112'd0, e.addr});
                    chk("l2_op", {126'd0, l2_read, l2_write}, e.wr ? 128'd1 : 128'd2);
                    if (e.wr) chk("l2_wdata", l2_wdata, e.wdata);
                end
            end
        end
    end

    // Caller is at a sample point; returns at the negedge where the request drops.
    task automatic wait_resp(bit cli, int budget);
        int n = 0;
        while (!(cli ? d_resp : i_resp) && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            total++;
            $display("FAIL resp_timeout cli=%0d got=no_resp exp=resp", cli);
        end
        @(negedge clk);
        if (cli) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    task automatic run_req(vec_t v);
        chk("idle_gap", {126'd0, l2_read, l2_write}, 128'd0);
        q.push_back(mk(v.cli, v.wr, v.addr, v.wdata));
        l2_lat = v.lat;
        if (v.cli) begin
            d_read = !v.wr;
            d_write = v.wr;
            d_addr = v.addr;
            d_wdata = v.wdata;
        end else begin
            i_read = 1'b1;
            i_addr = v.addr;
        end
        @(negedge clk);
        #2;
        chk("lat_op", {126'd0, l2_read, l2_write}, v.wr ? 128'd1 : 128'd2);
        wait_resp(v.cli, 40);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{cli: 0, wr: 0, addr: 16'h1230, wdata: '0,  lat: 5};
        vt[1] = '{cli: 1, wr: 1, addr: 16'h4000, wdata: PAT, lat: 3};
        vt[2] = '{cli: 1, wr: 0, addr: 16'h0BEE, wdata: '0,  lat: 2};
        vt[3] = '{cli: 0, wr: 0, addr: 16'h0000, wdata: '0,  lat: 1};
        vt[4] = '{cli: 0, wr: 0, addr: 16'h0010, wdata: '0,  lat: 1};
        vt[5] = '{cli: 0, wr: 0, addr: 16'h0020, wdata: '0,  lat: 1};

        rst = 1'b1;
        i_read = 1'b0;
        i_addr = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ops", {124'd0, l2_read, l2_write, i_resp, d_resp}, 128'd0);
        chk("rst_addr", {112'd0, l2_addr}, 128'd0);
        chk("rst_wdata", l2_wdata, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stale L2 response while idle is ignored.
        @(negedge clk);
        l2_auto = 1'b0;
        l2_resp = 1'b1;
        l2_rdata = PAT;
        #2;
        chk("stale_i", {127'd0, i_resp}, 128'd0);
        chk("stale_d", {127'd0, d_resp}, 128'd0);
        @(negedge clk);
        l2_resp = 1'b0;
        l2_auto = 1'b1;
        #2;
        chk("stale_idle", {126'd0, l2_read, l2_write}, 128'd0);
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_req(vt[k]);

        // Contention with last grant = I: D first, then I.
        q.push_back(mk(1, 0, 16'h3330, '0));
        q.push_back(mk(0, 0, 16'h2220, '0));
        l2_lat = 2;
        i_read = 1'b1;
        i_addr = 16'h2220;
        d_read = 1'b1;
        d_addr = 16'h3330;
        @(negedge clk);
        #2;
        chk("rr1_first", {112'd0, l2_addr}, 128'h3330);
        wait_resp(1, 40);
        #2;
        wait_resp(0, 40);

        // Second simultaneous pair alternates the same way.
        q.push_back(mk(1, 0, 16'h3340, '0));
        q.push_back(mk(0, 0, 16'h2240, '0));
        i_read = 1'b1;
        i_addr = 16'h2240;
        d_read = 1'b1;
        d_addr = 16'h3340;
        @(negedge clk);
        #2;
        chk("rr2_first", {112'd0, l2_addr}, 128'h3340);
        wait_resp(1, 40);
        #2;
        wait_resp(0, 40);

        // After a lone D grant, contention favours I.
        run_req('{cli: 1, wr: 0, addr: 16'h0100, wdata: '0, lat: 1});
        q.push_back(mk(0, 0, 16'h2260, '0));
        q.push_back(mk(1, 1, 16'h3360, ~PAT));
        i_read = 1'b1;
        i_addr = 16'h2260;
        d_write = 1'b1;
        d_addr = 16'h3360;
        d_wdata = ~PAT;
        @(negedge clk);
        #2;
        chk("rr3_first", {112'd0, l2_addr}, 128'h2260);
        wait_resp(0, 40);
        #2;
        wait_resp(1, 40);

        // Address and data held while the client changes its inputs.
        q.push_back(mk(1, 1, 16'h4000, PAT));
        l2_lat = 6;
        d_write = 1'b1;
        d_addr = 16'h4000;
        d_wdata = PAT;
        @(negedge clk);
        #2;
        chk("stab_op", {126'd0, l2_read, l2_write}, 128'd1);
        @(negedge clk);
        d_addr = 16'hFFFF;
        d_wdata = ~PAT;
        #2;
        chk("addr_hold", {112'd0, l2_addr}, 128'h4000);
        chk("wdata_hold", l2_wdata, PAT);
        wait_resp(1, 40);

        // Reset in the middle of an I transfer discards it.
        l2_auto = 1'b0;
        i_read = 1'b1;
        i_addr = 16'h5550;
        @(negedge clk);
        #2;
        chk("pre_rst_rd", {127'd0, l2_read}, 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_read = 1'b0;
        l2_resp = 1'b1;
        l2_rdata = PAT;
        #2;
        chk("mid_rst_rd", {126'd0, l2_read, l2_write}, 128'd0);
        chk("mid_rst_addr", {112'd0, l2_addr}, 128'd0);
        chk("late_i_resp", {127'd0, i_resp}, 128'd0);
        @(negedge clk);
        l2_resp = 1'b0;
        l2_auto = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_empty", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
